// File: rtl/multi_ball_engine.sv
// ---------------------------------------------------------------------------
// multi_ball_engine
//
// Bouncing-sprite engine for the VGA demo.  Holds NUM_BALLS circular balls,
// advances them once per accepted frame_start with a small sequential update
// FSM (one ball per clock), and renders each pixel with a shadow ring, a
// per-ball palette and fixed lowest-index-wins priority.  The colour output is
// registered, so it lags hpos/vpos/display_on by one clock; the top level
// delays hsync/vsync by one clock to match.
//
// Optional feature (compile-time macro BOUNCE_COUNT_EN):
//   defined   -> adds output bounce_count[7:0], a saturating count of axis
//                reflections (x and y on the same ball in one cycle count 2).
//   undefined -> the port and its logic are absent.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-high reset
//   hpos, vpos   in   current pixel coordinate (10 bits each)
//   display_on   in   active-video qualifier
//   frame_start  in   one-cycle pulse issued during vertical blank
//   speed        in   pixels per frame per axis, sampled on accepted frame_start
//   pause        in   1 = frame_start ignored (motion frozen, rendering continues)
//   rgb          out  registered colour {R[1:0],G[1:0],B[1:0]}
//   busy         out  update FSM active
//   bounce_count out  reflection counter (BOUNCE_COUNT_EN only)
// ---------------------------------------------------------------------------
module multi_ball_engine #(
    parameter int NUM_BALLS    = 4,
    parameter int BALL_RADIUS  = 20,
    parameter int SHADOW_WIDTH = 4,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SPEED_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic               display_on,
    input  logic               frame_start,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    output logic [5:0]         rgb,
    output logic               busy
`ifdef BOUNCE_COUNT_EN
    ,
    output logic [7:0]         bounce_count
`endif
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    // Position limits: the ball centre stays a full radius inside the screen.
    localparam logic [10:0] POS_LO = 11'(BALL_RADIUS);
    localparam logic [10:0] X_HI   = 11'(H_ACTIVE - BALL_RADIUS);
    localparam logic [10:0] Y_HI   = 11'(V_ACTIVE - BALL_RADIUS);

    localparam logic [20:0] IN_R2 = 21'(BALL_RADIUS * BALL_RADIUS);
    localparam logic [20:0] SH_R2 = 21'((BALL_RADIUS + SHADOW_WIDTH) *
                                        (BALL_RADIUS + SHADOW_WIDTH));

    localparam logic [5:0] COL_OFF    = 6'b000000;
    localparam logic [5:0] COL_SHADOW = 6'b010101;
    localparam logic [5:0] COL_BG     = 6'b000010;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } state_t;

    // Result of advancing one axis of one ball by one frame.
    typedef struct packed {
        logic       bounce;
        logic       dir;
        logic [9:0] pos;
    } axis_step_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Advance one axis.  dir=1 moves towards hi, dir=0 towards POS_LO.
    // Everything is compared in 11 bits so pos+step can never wrap.
    function automatic axis_step_t axis_step(input logic [9:0]         pos,
                                             input logic               dir,
                                             input logic [SPEED_W-1:0] step,
                                             input logic [10:0]        hi);
        logic [10:0] p;
        logic [10:0] s;
        logic [10:0] sum;
        logic [10:0] diff;
        axis_step_t  r;
        p    = {1'b0, pos};
        s    = 11'(step);
        sum  = p + s;
        diff = p - s;
        r.bounce = 1'b0;
        r.dir    = dir;
        r.pos    = pos;
        // A zero step neither moves nor reflects, even when sitting on a wall.
        if (step != '0) begin
            if (dir) begin
                if (sum >= hi) begin
                    r.pos    = hi[9:0];
                    r.dir    = 1'b0;
                    r.bounce = 1'b1;
                end else begin
                    r.pos = sum[9:0];
                end
            end else begin
                if (p < POS_LO + s) begin
                    r.pos    = POS_LO[9:0];
                    r.dir    = 1'b1;
                    r.bounce = 1'b1;
                end else begin
                    r.pos = diff[9:0];
                end
            end
        end
        return r;
    endfunction

    // Squared distance between pixel (px,py) and centre (cx,cy).  Magnitudes
    // are at most 1023, so the sum of two squares still fits in 21 bits.
    function automatic logic [20:0] dist2(input logic [9:0] px,
                                          input logic [9:0] cx,
                                          input logic [9:0] py,
                                          input logic [9:0] cy);
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] mag_x;
        logic [10:0] mag_y;
        logic [20:0] ex;
        logic [20:0] ey;
        dx    = {1'b0, px} - {1'b0, cx};
        dy    = {1'b0, py} - {1'b0, cy};
        mag_x = dx[10] ? -dx : dx;
        mag_y = dy[10] ? -dy : dy;
        ex    = {10'b0, mag_x};
        ey    = {10'b0, mag_y};
        return ex * ex + ey * ey;
    endfunction

    function automatic logic [5:0] palette(input logic [1:0] k);
        case (k)
            2'd0:    return 6'b111000;
            2'd1:    return 6'b110000;
            2'd2:    return 6'b001100;
            default: return 6'b110011;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [SPEED_W-1:0]   spd;
    logic [9:0]           ball_x [NUM_BALLS];
    logic [9:0]           ball_y [NUM_BALLS];
    logic [NUM_BALLS-1:0] dir_x;
    logic [NUM_BALLS-1:0] dir_y;

    axis_step_t next_x;
    axis_step_t next_y;

    // Next position of the ball currently addressed by the update FSM.
    always_comb begin
        next_x = axis_step(ball_x[idx], dir_x[idx], spd, X_HI);
        next_y = axis_step(ball_y[idx], dir_y[idx], spd, Y_HI);
    end

`ifdef BOUNCE_COUNT_EN
    logic [8:0] bounce_sum;

    // Widened by one bit so the saturation test can look at the carry.
    always_comb begin
        bounce_sum = {1'b0, bounce_count} + 9'(next_x.bounce) + 9'(next_y.bounce);
    end
`endif

    // -----------------------------------------------------------------------
    // Update FSM: one ball per clock while busy
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values and simulation matches the netlist.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            idx   <= '0;
            spd   <= '0;
            // NOTE: the ball table is a handful of flops, not a RAM, and its
            // reset contents define the starting layout, so it is reset here.
            for (int i = 0; i < NUM_BALLS; i++) begin
                ball_x[i] <= 10'(100 + 60 * i);
                ball_y[i] <= 10'(120 + 30 * i);
                dir_x[i]  <= ~i[0];
                dir_y[i]  <= ~i[1];
            end
`ifdef BOUNCE_COUNT_EN
            bounce_count <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start && !pause) begin
                        spd   <= speed;
                        idx   <= '0;
                        state <= ST_UPDATE;
                        busy  <= 1'b1;
                    end
                end

                ST_UPDATE: begin
                    ball_x[idx] <= next_x.pos;
                    ball_y[idx] <= next_y.pos;
                    dir_x[idx]  <= next_x.dir;
                    dir_y[idx]  <= next_y.dir;
`ifdef BOUNCE_COUNT_EN
                    bounce_count <= bounce_sum[8] ? 8'hFF : bounce_sum[7:0];
`endif
                    if (idx == IDX_W'(NUM_BALLS - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Renderer: combinational hit test, registered colour
    // -----------------------------------------------------------------------
    logic [20:0] d2 [NUM_BALLS];
    logic        hit;
    logic        shadow;
    logic [5:0]  hit_colour;
    logic [5:0]  pix_next;

    // NOTE: every variable below gets a default before the loop so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        hit        = 1'b0;
        shadow     = 1'b0;
        hit_colour = COL_BG;
        for (int i = 0; i < NUM_BALLS; i++) begin
            d2[i] = dist2(hpos, ball_x[i], vpos, ball_y[i]);
            // Only the first (lowest-index) ball that covers the pixel wins.
            if (!hit && d2[i] <= IN_R2) begin
                hit        = 1'b1;
                hit_colour = palette(2'(i));
            end
            if (d2[i] <= SH_R2) begin
                shadow = 1'b1;
            end
        end

        if (!display_on) begin
            pix_next = COL_OFF;
        end else if (hit) begin
            pix_next = hit_colour;
        end else if (shadow) begin
            pix_next = COL_SHADOW;
        end else begin
            pix_next = COL_BG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= COL_OFF;
        end else begin
            rgb <= pix_next;
        end
    end

endmodule

// File: tb/tb_multi_ball_engine.sv
// ---------------------------------------------------------------------------
// tb_multi_ball_engine
//
// Self-checking bench for multi_ball_engine with default parameters.  A
// behavioural model keeps ball positions as plain integers, applies the
// frame motion rules arithmetically and computes expected pixel colours.
// Directed scenarios cover reset, pause, busy length, ignored frame_start,
// reset during an update and a wall bounce; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_multi_ball_engine;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       frame_start;
    logic [2:0] speed;
    logic       pause;
    logic [5:0] rgb;
    logic       busy;
`ifdef BOUNCE_COUNT_EN
    logic [7:0] bounce_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int mx [NB];
    int my [NB];
    int mdx[NB];
    int mdy[NB];
    int m_bounces;

    always #5 clk = ~clk;

    multi_ball_engine dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .frame_start (frame_start),
        .speed       (speed),
        .pause       (pause),
        .rgb         (rgb),
        .busy        (busy)
`ifdef BOUNCE_COUNT_EN
        ,
        .bounce_count(bounce_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ model
    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]  = 100 + 60 * i;
            my[i]  = 120 + 30 * i;
            mdx[i] = ((i & 1) == 0) ? 1 : 0;
            mdy[i] = ((i & 2) == 0) ? 1 : 0;
        end
        m_bounces = 0;
    endtask

    // Move one coordinate by s towards hi (d=1) or towards 20 (d=0).
    task automatic model_axis(inout int p, inout int d, input int s, input int hi);
        if (s == 0) return;
        if (d == 1) begin
            if (p + s >= hi) begin
                p = hi;
                d = 0;
                m_bounces++;
            end else begin
                p = p + s;
            end
        end else begin
            if (p < 20 + s) begin
                p = 20;
                d = 1;
                m_bounces++;
            end else begin
                p = p - s;
            end
        end
    endtask

    task automatic model_frame(input int s);
        for (int i = 0; i < NB; i++) begin
            model_axis(mx[i], mdx[i], s, 620);
            model_axis(my[i], mdy[i], s, 460);
        end
    endtask

    function automatic logic [5:0] model_rgb(input int h, input int v, input bit don);
        int d;
        if (!don) return 6'b000000;
        for (int i = 0; i < NB; i++) begin
            d = (h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]);
            if (d <= 400) begin
                case (i % 4)
                    0:       return 6'b111000;
                    1:       return 6'b110000;
                    2:       return 6'b001100;
                    default: return 6'b110011;
                endcase
            end
        end
        for (int i = 0; i < NB; i++) begin
            d = (h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]);
            if (d <= 576) return 6'b010101;
        end
        return 6'b000010;
    endfunction

    // --------------------------------------------------------------- helpers
    task automatic check_pixel(input string tag, input int h, input int v, input bit don);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = don;
        tick();
        check(tag, rgb, model_rgb(h, v, don));
    endtask

    // Issue one frame_start and measure how long busy stays high.
    task automatic run_frame(input string tag, input int s, input bit p);
        int cnt;
        int guard;
        frame_start = 1'b1;
        speed       = 3'(s);
        pause       = p;
        tick();
        frame_start = 1'b0;
        pause       = 1'b0;
        cnt   = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin
            cnt++;
            guard++;
            tick();
        end
        check(tag, cnt, p ? 0 : NB);
        if (!p) model_frame(s);
    endtask

    function automatic int clamp(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    // --------------------------------------------------------------- stimulus
    initial begin
        int cnt;
        int b;
        int h;
        int v;

        reset       = 1'b1;
        hpos        = 10'd100;
        vpos        = 10'd120;
        display_on  = 1'b1;
        frame_start = 1'b0;
        speed       = 3'd0;
        pause       = 1'b0;
        model_reset();

        // Reset held for three cycles: colour off, FSM idle.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_rgb", rgb, 6'b000000);
            check("reset_busy", busy, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("post_reset_ball0", rgb, 6'b111000);
        display_on = 1'b0;
        tick();
        check("display_off", rgb, 6'b000000);
        check("idle_busy", busy, 1'b0);

        // Pause: ten pulses, none accepted, ball 0 stays put.
        for (int k = 0; k < 10; k++) begin
            run_frame("pause_busy", 2, 1'b1);
        end
        hpos = 10'd100; vpos = 10'd120; display_on = 1'b1;
        tick();
        check("pause_ball0", rgb, 6'b111000);
        check_pixel("pause_shadow", 121, 120, 1'b1);

        // First real frame at speed 2: ball 0 to (102,122).
        run_frame("speed2_busy", 2, 1'b0);
        hpos = 10'd122; vpos = 10'd122; tick();
        check("edge_in_ball", rgb, 6'b111000);
        hpos = 10'd123; tick();
        check("edge_shadow", rgb, 6'b010101);
        hpos = 10'd127; tick();
        check("edge_background", rgb, 6'b000010);

        // Second frame_start two cycles into an update must be ignored.
        frame_start = 1'b1;
        speed       = 3'd2;
        tick();
        frame_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy === 1'b1) cnt++;
            frame_start = (k == 1);
            speed       = (k == 1) ? 3'd5 : 3'd2;
            tick();
        end
        frame_start = 1'b0;
        check("double_fs_busy", cnt, NB);
        model_frame(2);
        check_pixel("double_fs_in", mx[0] + 20, my[0], 1'b1);
        check_pixel("double_fs_shadow", mx[0] + 21, my[0], 1'b1);

        // Reset on the second UPDATE cycle aborts and restores everything.
        frame_start = 1'b1;
        speed       = 3'd3;
        tick();
        frame_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        model_reset();
        hpos = 10'd160; vpos = 10'd150; display_on = 1'b1;
        tick();
        check("abort_ball1", rgb, 6'b110000);
        hpos = 10'd100; vpos = 10'd120;
        tick();
        check("abort_ball0", rgb, 6'b111000);
        check_pixel("abort_ball2", 220, 180, 1'b1);

        // Speed 7 for 75 frames drives ball 0 into the right wall at 620.
        for (int k = 0; k < 75; k++) begin
            run_frame("speed7_busy", 7, 1'b0);
        end
        check_pixel("wall_in", 600, my[0], 1'b1);
        check_pixel("wall_outer", 599, my[0], 1'b1);
        check_pixel("wall_right", 639, my[0], 1'b1);
`ifdef BOUNCE_COUNT_EN
        check("bounce_75", bounce_count, (m_bounces > 255) ? 255 : m_bounces);
`endif
        run_frame("speed7_busy", 7, 1'b0);
        check_pixel("after_bounce_in", 593, my[0], 1'b1);
        check_pixel("after_bounce_out", 592, my[0], 1'b1);

        // Zero speed: accepted, but nothing moves or reflects.
        run_frame("speed0_busy", 0, 1'b0);
        check_pixel("speed0_pos", mx[0] - 20, my[0], 1'b1);

        // Randomized frames and pixel probes near random balls.
        for (int f = 0; f < 40; f++) begin
            run_frame("rand_busy", int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            for (int q = 0; q < 4; q++) begin
                b = int'($urandom_range(0, NB - 1));
                h = clamp(mx[b] + int'($urandom_range(0, 52)) - 26, 0, 639);
                v = clamp(my[b] + int'($urandom_range(0, 52)) - 26, 0, 479);
                check_pixel("rand_pixel", h, v, ($urandom_range(0, 7) != 0));
            end
        end
`ifdef BOUNCE_COUNT_EN
        check("bounce_final", bounce_count, (m_bounces > 255) ? 255 : m_bounces);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
